// File: rtl/wb_i2s.sv
// ============================================================================
// wb_i2s
// ----------------------------------------------------------------------------
// Wishbone-classic slave that feeds a stereo I2S transmitter. Software pushes
// 32-bit words {L[15:0], R[15:0]} into a sample FIFO. A programmable divider
// generates the bit clock, and a 32-slot serializer shifts each word out MSB
// first in standard I2S format, with data lagging word select by one slot.
// While the transmitter is enabled and interrupts are enabled, a level
// interrupt is raised whenever the FIFO holds half its depth or less.
//
// Register map (word address adr_i[1:0]):
//    0 DATA   (wo) push {L,R}; reads return 0
//    1 STATUS      [15:0] level, [16] empty, [17] full,
//                  [18] underrun (sticky, W1C), [19] overflow (sticky, W1C)
//    2 CTRL   (rw) [0] enable, [1] irq_en, [2] flush (self-clearing, reads 0)
//    3 DIV    (rw) [7:0] divider, bclk half-period = DIV+1 clk_i cycles
//
// Ports:
//    clk_i          system clock
//    rst_i          asynchronous reset, active low
//    cyc_i, stb_i   Wishbone cycle / strobe
//    we_i           Wishbone write enable
//    adr_i[29:0]    word address, only [1:0] decoded
//    sel_i[3:0]     byte selects, ignored (full-word accesses only)
//    dat_i[31:0]    write data
//    ack_o          one-cycle acknowledge, no wait states
//    dat_o[31:0]    read data, valid with ack_o
//    irq            level interrupt
//    i2s_bclk       bit clock
//    i2s_wsel       word select, 0 = left, 1 = right
//    i2s_dout       serial data
// ============================================================================
module wb_i2s #(
   parameter int FIFO_DEPTH = 64,
   parameter int DIV_RESET  = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [29:0] adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq,
   output logic        i2s_bclk,
   output logic        i2s_wsel,
   output logic        i2s_dout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LEVEL_HALF = LW'(FIFO_DEPTH / 2);

   // Register address decode values
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   // ------------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------------
   logic       req;
   logic       rd_req;
   logic       wr_req;
   logic       wr_data;
   logic       wr_status;
   logic       wr_ctrl;
   logic       wr_div;
   logic       flush;
   logic [1:0] reg_sel;

   // Only the low address bits and the full-word data path matter; the rest
   // of the bus is folded here so it is visibly consumed.
   logic       unused_bus;
   assign unused_bus = ^{adr_i[29:2], sel_i};

   // A new request is accepted only while ack_o is low, so every access is
   // acknowledged exactly once and back-to-back strobes get one idle cycle.
   assign req       = cyc_i & stb_i & ~ack_o;
   assign rd_req    = req & ~we_i;
   assign wr_req    = req & we_i;
   assign reg_sel   = adr_i[1:0];
   assign wr_data   = wr_req & (reg_sel == REG_DATA);
   assign wr_status = wr_req & (reg_sel == REG_STATUS);
   assign wr_ctrl   = wr_req & (reg_sel == REG_CTRL);
   assign wr_div    = wr_req & (reg_sel == REG_DIV);
   assign flush     = wr_ctrl & dat_i[2];

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic          ctrl_en;
   logic          ctrl_irq_en;
   logic [7:0]    div_reg;
   logic [7:0]    div_act;
   logic [7:0]    div_cnt;
   logic          bclk;
   logic [4:0]    slot;
   logic [31:0]   shift;
   logic          underrun;
   logic          overflow;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [31:0]   mem [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Event decode shared by the FIFO, the serializer and the flags
   // ------------------------------------------------------------------------
   logic fifo_empty;
   logic fifo_full;
   logic wrap;
   logic fall;
   logic pop_evt;
   logic do_pop;
   logic do_push;
   logic set_underrun;
   logic set_overflow;

   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == LEVEL_FULL);

   // The divider only runs while enabled; a wrap with bclk high is the
   // falling edge that advances the slot counter.
   assign wrap    = ctrl_en & (div_cnt == div_act);
   assign fall    = wrap & bclk;
   assign pop_evt = fall & (slot == 5'd0);

   // Flush overrides both sides of the FIFO. A push into a full FIFO is
   // still accepted when a pop frees an entry in the same cycle.
   assign do_pop       = pop_evt & ~fifo_empty & ~flush;
   assign do_push      = wr_data & (~fifo_full | do_pop) & ~flush;
   assign set_underrun = pop_evt & fifo_empty & ~flush;
   assign set_overflow = wr_data & fifo_full & ~do_pop & ~flush;

   // ------------------------------------------------------------------------
   // Bus response: single-cycle ack, read data registered alongside it
   // ------------------------------------------------------------------------
   logic [31:0] rd_data;

   always_comb begin
      rd_data = 32'd0;
      case (reg_sel)
         REG_STATUS: rd_data = {12'd0, overflow, underrun, fifo_full,
                                fifo_empty, 16'(level)};
         REG_CTRL:   rd_data = {30'd0, ctrl_irq_en, ctrl_en};
         REG_DIV:    rd_data = {24'd0, div_reg};
         default:    rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o <= 1'b0;
         dat_o <= 32'd0;
      end else begin
         ack_o <= req;
         dat_o <= rd_req ? rd_data : 32'd0;
      end
   end

   // ------------------------------------------------------------------------
   // Control and divider registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         div_reg     <= 8'(DIV_RESET);
      end else begin
         if (wr_ctrl) begin
            ctrl_en     <= dat_i[0];
            ctrl_irq_en <= dat_i[1];
         end
         if (wr_div) begin
            div_reg <= dat_i[7:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sticky status flags: a set in the same cycle beats a write-1-clear
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (set_underrun) begin
            underrun <= 1'b1;
         end else if (wr_status && dat_i[18]) begin
            underrun <= 1'b0;
         end
         if (set_overflow) begin
            overflow <= 1'b1;
         end else if (wr_status && dat_i[19]) begin
            overflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sample FIFO pointers and fill level
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Sample storage carries no reset; the level counter alone defines which
   // entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= dat_i;
      end
   end

   // ------------------------------------------------------------------------
   // Bit clock divider and serializer
   // ------------------------------------------------------------------------
   // The active divider value is resampled from the register at every wrap
   // (and continuously while idle), so a DIV write never shortens or
   // stretches the half-period already in progress. The word is loaded on
   // the falling edge entering slot 1, which puts L[15] one slot after the
   // wsel transition and leaves R[0] in slot 0 of the following frame.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div_act <= 8'(DIV_RESET);
         div_cnt <= 8'd0;
         bclk    <= 1'b0;
         slot    <= 5'd0;
         shift   <= 32'd0;
      end else if (!ctrl_en) begin
         div_act <= div_reg;
         div_cnt <= 8'd0;
         bclk    <= 1'b0;
         slot    <= 5'd0;
         shift   <= 32'd0;
      end else if (wrap) begin
         div_act <= div_reg;
         div_cnt <= 8'd0;
         bclk    <= ~bclk;
         if (bclk) begin
            slot <= slot + 5'd1;
            if (pop_evt) begin
               shift <= do_pop ? mem[rd_ptr] : 32'd0;
            end else begin
               shift <= {shift[30:0], 1'b0};
            end
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // All pins come straight from registers that only move on falling edges
   // (or on disable/reset), so they never glitch.
   assign i2s_bclk = bclk;
   assign i2s_wsel = slot[4];
   assign i2s_dout = shift[31];

   // ------------------------------------------------------------------------
   // Interrupt: registered half-empty level
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         irq <= 1'b0;
      end else begin
         irq <= ctrl_irq_en & ctrl_en & (level <= LEVEL_HALF);
      end
   end

endmodule

// File: tb/tb_wb_i2s.sv
// ============================================================================
// tb_wb_i2s
// ----------------------------------------------------------------------------
// Testbench for wb_i2s. Samples pushed over Wishbone are queued in a
// scoreboard; a monitor rebuilds each serialized frame from the I2S pins and
// compares it (and the word-select pattern) against the queued sample.
// ============================================================================
module tb_wb_i2s;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cyc_i = 1'b0;
   logic        stb_i = 1'b0;
   logic        we_i  = 1'b0;
   logic [29:0] adr_i = 30'd0;
   logic [3:0]  sel_i = 4'hF;
   logic [31:0] dat_i = 32'd0;
   logic        ack_o;
   logic [31:0] dat_o;
   logic        irq;
   logic        i2s_bclk;
   logic        i2s_wsel;
   logic        i2s_dout;

   wb_i2s #(
      .FIFO_DEPTH (64),
      .DIV_RESET  (8)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .cyc_i    (cyc_i),
      .stb_i    (stb_i),
      .we_i     (we_i),
      .adr_i    (adr_i),
      .sel_i    (sel_i),
      .dat_i    (dat_i),
      .ack_o    (ack_o),
      .dat_o    (dat_o),
      .irq      (irq),
      .i2s_bclk (i2s_bclk),
      .i2s_wsel (i2s_wsel),
      .i2s_dout (i2s_dout)
   );

   // 100 MHz system clock
   always #5 clk_i = ~clk_i;

   int          total = 0;
   int          bad = 0;
   int          framesDone = 0;
   bit          enableModel = 1'b0;
   logic [31:0] expQ [$];

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Advance n clock edges and settle just after the last one
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Wishbone write: one idle edge (lets a previous ack drop), then the
   // accepting edge; returns 1 ns after the edge on which the write lands
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      @(posedge clk_i);
      #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b1;
      adr_i = {28'd0, addr};
      dat_i = data;
      @(posedge clk_i);
      #1;
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
   endtask

   // Wishbone read with the same timing, checking the acknowledge too
   task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
      @(posedge clk_i);
      #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b0;
      adr_i = {28'd0, addr};
      @(posedge clk_i);
      #1;
      checkOutput("read_ack", {31'd0, ack_o}, 32'd1);
      data  = dat_o;
      cyc_i = 1'b0;
      stb_i = 1'b0;
   endtask

   task automatic readCheck(input logic [1:0] addr, input logic [31:0] exp,
                            input string tag);
      logic [31:0] d;
      busRead(addr, d);
      checkOutput(tag, d, exp);
   endtask

   // Push a sample and mirror it in the scoreboard (dropped when full)
   task automatic pushSample(input logic [31:0] data);
      applyStimulus(2'd0, data);
      if (expQ.size() < 64) begin
         expQ.push_back(data);
      end
   endtask

   // CTRL write with matching model update
   task automatic setCtrl(input logic [31:0] v);
      applyStimulus(2'd2, v);
      enableModel = v[0];
      if (v[2]) begin
         expQ.delete();
      end
   endtask

   // ------------------------------------------------------------------------
   // Frame monitor: follows bclk falling edges, assembles the 32 bits from
   // slot 1 through slot 0 of the next frame and compares with the sample
   // popped from the scoreboard when the frame started (0 when empty).
   // ------------------------------------------------------------------------
   logic        prevBclk = 1'b0;
   int          monSlot = 0;
   int          frmIdx = 0;
   bit          frmActive = 1'b0;
   logic [31:0] frmBits = 32'd0;
   logic [31:0] wselBits = 32'd0;
   logic [31:0] curExp = 32'd0;

   always @(negedge clk_i) begin
      if (!rst_i || !enableModel) begin
         monSlot   = 0;
         frmActive = 1'b0;
      end else if (prevBclk && !i2s_bclk) begin
         monSlot = (monSlot + 1) % 32;
         if (monSlot == 1) begin
            frmActive = 1'b1;
            frmIdx    = 0;
            frmBits   = 32'd0;
            wselBits  = 32'd0;
            if (expQ.size() > 0) begin
               curExp = expQ.pop_front();
            end else begin
               curExp = 32'd0;
            end
         end
         if (frmActive) begin
            frmBits  = {frmBits[30:0], i2s_dout};
            wselBits = {wselBits[30:0], i2s_wsel};
            frmIdx++;
            if (frmIdx == 32) begin
               checkOutput("frame_data", frmBits, curExp);
               checkOutput("frame_wsel", wselBits, 32'h0001_FFFE);
               framesDone++;
               frmActive = 1'b0;
            end
         end
      end
      prevBclk = i2s_bclk;
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      logic [3:0] seq;

      $display("[TB] reset");
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      waitCycles(1);
      checkOutput("rst_ack", {31'd0, ack_o}, 32'd0);
      checkOutput("rst_dat", dat_o, 32'd0);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_pins", {29'd0, i2s_bclk, i2s_wsel, i2s_dout}, 32'd0);
      readCheck(2'd1, 32'h0001_0000, "rst_status");
      readCheck(2'd3, 32'd8, "rst_div");
      readCheck(2'd2, 32'd0, "rst_ctrl");

      $display("[TB] serializer pattern");
      applyStimulus(2'd3, 32'd1);
      readCheck(2'd3, 32'd1, "div_rw");
      pushSample(32'hA5A5_3C3C);
      setCtrl(32'd1);
      seq = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i);
         #1;
         seq = {seq[2:0], i2s_bclk};
      end
      checkOutput("bclk_start", {28'd0, seq}, 32'h0000_0006);
      waitCycles(130);
      checkOutput("frames_t2", framesDone, 32'd1);
      setCtrl(32'd0);
      waitCycles(1);
      checkOutput("dis_pins", {29'd0, i2s_bclk, i2s_wsel, i2s_dout}, 32'd0);
      readCheck(2'd1, 32'h0005_0000, "unr_after_t2");
      applyStimulus(2'd1, 32'h000C_0000);
      readCheck(2'd1, 32'h0001_0000, "flags_clr");

      $display("[TB] overflow");
      for (int i = 0; i < 65; i++) begin
         pushSample(32'h1000_0000 + 32'(i));
      end
      readCheck(2'd1, 32'h000A_0040, "ovf_status");
      applyStimulus(2'd1, 32'h0008_0000);
      readCheck(2'd1, 32'h0002_0040, "ovf_clr");

      $display("[TB] half-empty interrupt");
      setCtrl(32'd4);
      readCheck(2'd1, 32'h0001_0000, "flush_idle");
      for (int i = 0; i < 33; i++) begin
         pushSample($urandom);
      end
      readCheck(2'd1, 32'h0000_0021, "lvl33");
      setCtrl(32'd3);
      checkOutput("irq_33a", {31'd0, irq}, 32'd0);
      waitCycles(4);
      checkOutput("irq_33b", {31'd0, irq}, 32'd0);
      waitCycles(1);
      checkOutput("irq_32", {31'd0, irq}, 32'd1);
      waitCycles(260);
      checkOutput("frames_t4", framesDone, 32'd3);
      setCtrl(32'd4);
      waitCycles(1);
      checkOutput("irq_off", {31'd0, irq}, 32'd0);

      $display("[TB] underrun");
      setCtrl(32'd1);
      waitCycles(4);
      readCheck(2'd1, 32'h0005_0000, "underrun");
      waitCycles(130);
      checkOutput("frames_t5", framesDone, 32'd4);
      setCtrl(32'd0);
      applyStimulus(2'd1, 32'h000C_0000);

      $display("[TB] flush against slot-1 pop");
      for (int i = 0; i < 5; i++) begin
         pushSample(32'hFFFF_FFFF);
      end
      setCtrl(32'd1);
      waitCycles(2);
      setCtrl(32'd5);
      readCheck(2'd1, 32'h0001_0000, "flush_pop");
      waitCycles(130);
      checkOutput("frames_t6", framesDone, 32'd5);
      setCtrl(32'd0);

      $display("[TB] async reset mid-frame");
      setCtrl(32'd1);
      waitCycles(80);
      checkOutput("wsel_mid", {31'd0, i2s_wsel}, 32'd1);
      #3;
      rst_i = 1'b0;
      enableModel = 1'b0;
      expQ.delete();
      #1;
      checkOutput("arst_pins", {29'd0, i2s_bclk, i2s_wsel, i2s_dout}, 32'd0);
      #2;
      rst_i = 1'b1;
      waitCycles(1);
      readCheck(2'd1, 32'h0001_0000, "post_rst_status");
      readCheck(2'd3, 32'd8, "post_rst_div");
      readCheck(2'd2, 32'd0, "post_rst_ctrl");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_i2s.md
Name: wb_i2s

Overview:
- Wishbone-classic slave on a free slot of the peripheral arbiter, driving the audio pins i2s_bclk, i2s_wsel and i2s_dout.
- Software writes 16+16-bit stereo samples into a sample FIFO.
- A divider-clocked serializer shifts the samples out in I2S format, MSB first.
- A level interrupt goes to the interrupt controller when the FIFO drains to half.

Parameters:
- FIFO_DEPTH, 64, sample FIFO entries; power of 2, 4..256.
- DIV_RESET, 8, reset value of DIV; bclk half-period = DIV+1 clk_i cycles.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe (slot select from the arbiter).
- we_i  in  1  write enable.
- adr_i  in  30  word address; only [1:0] decoded.
- sel_i  in  4  byte selects; ignored, all accesses are full-word.
- dat_i  in  32  write data.
- ack_o  out  1  Wishbone acknowledge.
- dat_o  out  32  read data.
- irq  out  1  level interrupt.
- i2s_bclk  out  1  bit clock.
- i2s_wsel  out  1  word select; 0 = left, 1 = right.
- i2s_dout  out  1  serial data.

Behaviour:
- Reset: ack_o=0, dat_o=0, irq=0, i2s_bclk=0, i2s_wsel=0, i2s_dout=0. FIFO empty. CTRL=0, DIV=DIV_RESET, sticky flags cleared, slot=0, divider count=0.
- Bus handshake:
  - ack_o pulses for one cycle, the cycle after cyc_i&stb_i&!ack_o. No wait states.
  - A write takes effect in the same cycle that ack_o is asserted. Read data is valid with ack_o.
- Register map, by adr_i[1:0]:
  - 0 DATA (wo): push dat_i = {L[15:0], R[15:0]}. Reads return 0.
  - 1 STATUS: [15:0] FIFO level, [16] empty, [17] full, [18] underrun (sticky), [19] overflow (sticky). Writing 1 to bit 18 or 19 clears that flag; other bits read-only.
  - 2 CTRL (rw): [0] enable, [1] irq_en. [2] flush is self-clearing and reads 0.
  - 3 DIV (rw): [7:0] divider.
- Push when full: data dropped, overflow set.
- Bit clock:
  - While enable=1, the divider counts 0..DIV. At DIV it wraps to 0 and i2s_bclk toggles.
  - A falling edge is the clk_i cycle in which bclk toggles 1->0.
  - A DIV write applies from the next divider wrap.
- Serializer:
  - slot counter runs 0..31 and advances by 1 (mod 32) on each falling edge.
  - i2s_wsel = 1 for slots 16..31, else 0. It changes on falling edges only.
  - i2s_dout = shift register bit 31, updated on falling edges. Data lags wsel by one slot (standard I2S).
  - On the falling edge entering slot 1: pop the FIFO head into the shift register. If the FIFO is empty, load 0 and set underrun.
  - On all other falling edges: shift left by 1, filling with 0.
  - Result: slot 0 carries R[0] of the previous frame, slots 1..16 carry L[15:0], slots 17..31 carry R[15:1].
- Disable (enable 1->0): at the next clk_i edge, bclk/wsel/dout forced to 0, slot=0, divider=0, shift register=0. FIFO contents and flags are kept.
- Enable 0->1: the first toggle is a rising edge after DIV+1 cycles. The first falling edge enters slot 1 and pops.
- Simultaneous events:
  - Push and pop in the same cycle: both happen, level unchanged. Push while full succeeds if a pop occurs in the same cycle.
  - Flush vs push or pop in the same cycle: flush wins. Level=0, the push is dropped, the pop loads 0 and does not flag underrun.
  - A write-1-clear and a set of the same flag in the same cycle: the set wins.
- irq = irq_en & enable & (level <= FIFO_DEPTH/2), registered, so it follows the condition by one cycle.
- Async reset asserted mid-frame clears everything immediately. Outputs go to their reset values with no glitch beyond the reset itself.

Test Plan:
- Reset, then read STATUS -> 0x0001_0000 (empty). Read DIV -> 8. All i2s outputs 0. irq=0.
- DIV=1, push 0xA5A5_3C3C, enable -> bclk period 4 clk_i cycles. Slots 1..16 serialize 1010010110100101. Slots 17..31 serialize 001111000011110. wsel rises at slot 16.
- Push 64 words with enable=0, then one more push -> STATUS level 64, full=1, overflow=1. Write 0x0008_0000 to STATUS -> overflow=0, level stays 64.
- irq_en=1, enable=1, FIFO at 33 entries -> irq=0. It rises one cycle after the pop that leaves 32 entries.
- Enable with an empty FIFO -> dout stays 0 and underrun=1 after the first slot-1 pop.
- Flush written in the same cycle as a slot-1 pop with 5 entries queued -> level 0, underrun stays 0, dout 0 for the frame.
